// File: rtl/xgmii_udp_pktgen.sv
`timescale 1ns/1ps
// xgmii_udp_pktgen
//   Back-to-back IPv4/UDP test frame generator on one 64-bit XGMII TX lane.
//   Frame length, inter-frame gap, burst size and destination fan-out are
//   programmable. Each frame carries MAGIC, a send timestamp and a sequence
//   number. Optional per-second statistics are built when PKTGEN_STATS_EN
//   is defined; otherwise tx_pps/tx_throughput are tied to zero.
//
// Ports
//   sys_clk, sys_rst_n      XGMII clock, async active-low reset
//   enable                  level: start/continue generation
//   frame_len               bytes incl. FCS (rounded down to 8, clamped 64..LEN_MAX)
//   ifg                     idle words after terminate word (0 treated as 1)
//   burst_count             frames per enable, 0 = continuous
//   src_mac/dst_mac         MAC addresses
//   src_ip/dst_ip           IPv4 addresses, dst_ip is the round-robin base
//   global_counter          timestamp source, sampled at the PRE word
//   sec_oneshot             one-cycle pulse per second (stats window)
//   xgmii_txd/xgmii_txc     XGMII TX, lane 0 = txd[7:0] = first byte on wire
//   busy/done/frames_sent   burst status
//   tx_pps/tx_throughput    per-second frame and bit counters
module xgmii_udp_pktgen #(
    parameter logic [31:0] MAGIC   = 32'hA5A5_5A5A,
    parameter logic [15:0] LEN_MAX = 16'd1512,
    parameter int          NUM_DST = 4,
    parameter int          IFG_W   = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             enable,
    input  logic [15:0]      frame_len,
    input  logic [IFG_W-1:0] ifg,
    input  logic [31:0]      burst_count,
    input  logic [47:0]      src_mac,
    input  logic [47:0]      dst_mac,
    input  logic [31:0]      src_ip,
    input  logic [31:0]      dst_ip,
    input  logic [31:0]      global_counter,
    input  logic             sec_oneshot,
    output logic [63:0]      xgmii_txd,
    output logic [7:0]       xgmii_txc,
    output logic             busy,
    output logic             done,
    output logic [31:0]      frames_sent,
    output logic [31:0]      tx_pps,
    output logic [31:0]      tx_throughput
);
    localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;
    localparam logic [63:0] PRE_W  = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] TERM_W = 64'h0707_0707_0707_07FD;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_TERM, S_GAP} state_t;

    // Reflected Ethernet CRC, bit 0 of the data word goes first on the wire.
    function automatic logic [31:0] crc32_d64(input logic [31:0] c, input logic [63:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 64; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
        return r;
    endfunction

    function automatic logic [31:0] crc32_d32(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 32; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
        return r;
    endfunction

    // Header fields are built big-endian (first byte in [63:56]) then swapped
    // so that the first byte lands in lane 0.
    function automatic logic [63:0] bswap(input logic [63:0] be);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = be[56-8*i +: 8];
        return r;
    endfunction

    state_t            r_state, w_next;
    logic [12:0]       r_wcnt;
    logic [15:0]       r_len;
    logic [IFG_W-1:0]  r_gcnt;
    logic [31:0]       r_seq, r_ts, r_sip, r_ip_dst, r_frames, r_crc;
    logic [47:0]       r_smac, r_dmac;
    logic [7:0]        r_dst_idx;
    logic [19:0]       r_sum;
    logic [15:0]       r_csum;
    logic              r_done;
    logic [63:0]       r_txd;
    logic [7:0]        r_txc;

    logic [15:0]       w_len8, w_len, w_ip_len, w_udp_len;
    logic [31:0]       w_ip_dst, w_crc_nxt, w_crc_fin;
    logic [IFG_W-1:0]  w_ifg_eff;
    logic              w_gap_end, w_more, w_last;
    logic [19:0]       w_sum;
    logic [16:0]       w_f1;
    logic [15:0]       w_f2;
    logic [63:0]       w_be, w_word;
    logic [7:0]        w_ctl;
    logic              w_unused;

    assign w_unused  = ^{frame_len[2:0], sec_oneshot};

    assign w_len8    = {frame_len[15:3], 3'b000};
    assign w_len     = (w_len8 < 16'd64) ? 16'd64 : (w_len8 > LEN_MAX) ? LEN_MAX : w_len8;
    assign w_ip_len  = r_len - 16'd18;
    assign w_udp_len = r_len - 16'd38;
    assign w_ip_dst  = dst_ip + {24'h0, r_dst_idx};
    assign w_ifg_eff = (ifg == '0) ? IFG_W'(1) : ifg;
    assign w_gap_end = (r_gcnt >= w_ifg_eff);
    assign w_more    = enable && ((burst_count == 32'd0) || (r_frames < burst_count));
    assign w_last    = (r_state == S_DATA) && (r_wcnt == r_len[15:3] - 13'd1);

    // IPv4 header checksum: sum during word 0, fold/invert during word 1,
    // consumed at word 3.
    assign w_sum = 20'h04500 + 20'h04011 + {4'h0, w_ip_len} + {4'h0, r_seq[15:0]}
                 + {4'h0, r_sip[31:16]} + {4'h0, r_sip[15:0]}
                 + {4'h0, r_ip_dst[31:16]} + {4'h0, r_ip_dst[15:0]};
    assign w_f1  = {1'b0, r_sum[15:0]} + {13'h0, r_sum[19:16]};
    assign w_f2  = w_f1[15:0] + {15'h0, w_f1[16]};

    always_comb begin
        w_be = {8{8'hE5}};
        case (r_wcnt)
            13'd0: w_be = {r_dmac, r_smac[47:32]};
            13'd1: w_be = {r_smac[31:0], 16'h0800, 16'h4500};
            13'd2: w_be = {w_ip_len, r_seq[15:0], 16'h0000, 16'h4011};
            13'd3: w_be = {r_csum, r_sip, r_ip_dst[31:16]};
            13'd4: w_be = {r_ip_dst[15:0], 16'h0009, 16'h0009, w_udp_len};
            13'd5: w_be = {16'h0000, MAGIC, r_ts[31:16]};
            13'd6: w_be = {r_ts[15:0], r_seq, 16'h0000};
            default: w_be = {8{8'hE5}};
        endcase
    end

    always_comb begin
        w_next = r_state;
        w_ctl  = 8'hFF;
        w_word = IDLE_W;
        case (r_state)
            S_IDLE: if (enable && !r_done) w_next = S_PRE;
            S_PRE: begin
                w_ctl  = 8'h01;
                w_word = PRE_W;
                w_next = S_DATA;
            end
            S_DATA: begin
                w_ctl  = 8'h00;
                w_word = bswap(w_be);
                if (w_last) w_next = S_TERM;
            end
            S_TERM: begin
                w_word = TERM_W;
                w_next = S_GAP;
            end
            S_GAP: if (w_gap_end) w_next = w_more ? S_PRE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_wcnt    <= '0;
            r_len     <= 16'd64;
            r_gcnt    <= '0;
            r_seq     <= '0;
            r_ts      <= '0;
            r_sip     <= '0;
            r_ip_dst  <= '0;
            r_smac    <= '0;
            r_dmac    <= '0;
            r_dst_idx <= '0;
            r_sum     <= '0;
            r_csum    <= '0;
            r_frames  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (!enable) begin
                    r_done   <= 1'b0;
                    r_frames <= '0;
                end
                S_PRE: begin
                    r_wcnt   <= '0;
                    r_len    <= w_len;
                    r_ts     <= global_counter;
                    r_ip_dst <= w_ip_dst;
                    r_sip    <= src_ip;
                    r_smac   <= src_mac;
                    r_dmac   <= dst_mac;
                end
                S_DATA: begin
                    r_wcnt <= r_wcnt + 13'd1;
                    if (r_wcnt == 13'd0) r_sum  <= w_sum;
                    if (r_wcnt == 13'd1) r_csum <= ~w_f2;
                end
                S_TERM: begin
                    if (r_frames != '1) r_frames <= r_frames + 32'd1;
                    r_seq     <= r_seq + 32'd1;
                    r_dst_idx <= (r_dst_idx == 8'(NUM_DST - 1)) ? 8'd0 : r_dst_idx + 8'd1;
                    r_gcnt    <= IFG_W'(1);
                end
                S_GAP: begin
                    if (!w_gap_end) r_gcnt <= r_gcnt + 1'b1;
                    // Stopping with enable still high means the finite burst ran out.
                    else if (!w_more && enable) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output stage: registers the FSM word and splices the FCS into the
    // upper half of the last data word.
    assign w_crc_nxt = crc32_d64(r_crc, w_word);
    assign w_crc_fin = crc32_d32(r_crc, w_word[31:0]);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_txd <= IDLE_W;
            r_txc <= 8'hFF;
            r_crc <= '1;
        end else begin
            r_txc <= w_ctl;
            r_txd <= w_word;
            if (r_state == S_PRE) r_crc <= '1;
            else if (r_state == S_DATA) begin
                if (w_last) r_txd <= {~w_crc_fin, w_word[31:0]};
                else        r_crc <= w_crc_nxt;
            end
        end
    end

    assign xgmii_txd   = r_txd;
    assign xgmii_txc   = r_txc;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign frames_sent = r_frames;

`ifdef PKTGEN_STATS_EN
    logic [31:0] r_win_frames, r_win_bytes, r_pps, r_thr;
    logic        w_term;
    logic [31:0] w_f_acc, w_b_acc;
    logic [32:0] w_b_sum;

    // A TERM on the same cycle as sec_oneshot is folded into the value latched.
    assign w_term  = (r_state == S_TERM);
    assign w_f_acc = (w_term && (r_win_frames != '1)) ? r_win_frames + 32'd1 : r_win_frames;
    assign w_b_sum = {1'b0, r_win_bytes} + {17'h0, (w_term ? r_len : 16'h0)};
    assign w_b_acc = w_b_sum[32] ? '1 : w_b_sum[31:0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_win_frames <= '0;
            r_win_bytes  <= '0;
            r_pps        <= '0;
            r_thr        <= '0;
        end else if (sec_oneshot) begin
            r_pps        <= w_f_acc;
            r_thr        <= (|w_b_acc[31:29]) ? '1 : {w_b_acc[28:0], 3'b000};
            r_win_frames <= '0;
            r_win_bytes  <= '0;
        end else begin
            r_win_frames <= w_f_acc;
            r_win_bytes  <= w_b_acc;
        end
    end

    assign tx_pps        = r_pps;
    assign tx_throughput = r_thr;
`else
    assign tx_pps        = '0;
    assign tx_throughput = '0;
`endif

endmodule

// File: tb/tb_xgmii_udp_pktgen.sv
`timescale 1ns/1ps
module tb_xgmii_udp_pktgen;
    localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;
    localparam logic [63:0] PRE_W  = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] TERM_W = 64'h0707_0707_0707_07FD;

    logic        sys_clk = 1'b0, sys_rst_n = 1'b1, enable = 1'b0, sec_oneshot = 1'b0;
    logic [15:0] frame_len = 16'd64;
    logic [31:0] ifg = 32'd1, burst_count = 32'd0;
    logic [47:0] src_mac = 48'h02AA_BBCC_DD01, dst_mac = 48'h0211_2233_4455;
    logic [31:0] src_ip = 32'h0A00_1464, dst_ip = 32'h0A00_1501, global_counter = 32'hCAFE_0001;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        busy, done;
    logic [31:0] frames_sent, tx_pps, tx_throughput;

    xgmii_udp_pktgen dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
        .frame_len(frame_len), .ifg(ifg), .burst_count(burst_count),
        .src_mac(src_mac), .dst_mac(dst_mac), .src_ip(src_ip), .dst_ip(dst_ip),
        .global_counter(global_counter), .sec_oneshot(sec_oneshot),
        .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .busy(busy), .done(done),
        .frames_sent(frames_sent), .tx_pps(tx_pps), .tx_throughput(tx_throughput)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // ---------------- scoreboard model ----------------
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    logic [31:0] m_seq = 32'd0;
    int          m_idx = 0;

    task automatic push_frame(input int L);
        logic [7:0]  b[$];
        logic [31:0] dip, crc, sum;
        logic [15:0] ipl, udl, cs;
        dip = dst_ip + m_idx;
        ipl = 16'(L - 18);
        udl = 16'(L - 38);
        for (int i = 0; i < 6; i++) b.push_back(dst_mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) b.push_back(src_mac[47-8*i -: 8]);
        b.push_back(8'h08); b.push_back(8'h00);
        b.push_back(8'h45); b.push_back(8'h00); b.push_back(ipl[15:8]); b.push_back(ipl[7:0]);
        b.push_back(m_seq[15:8]); b.push_back(m_seq[7:0]); b.push_back(8'h00); b.push_back(8'h00);
        b.push_back(8'h40); b.push_back(8'h11); b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 0; i < 4; i++) b.push_back(src_ip[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) b.push_back(dip[31-8*i -: 8]);
        sum = 32'd0;
        for (int k = 14; k < 34; k += 2) sum = sum + {16'h0, b[k], b[k+1]};
        while (sum[31:16] != 16'h0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        cs = ~sum[15:0];
        b[24] = cs[15:8]; b[25] = cs[7:0];
        b.push_back(8'h00); b.push_back(8'h09); b.push_back(8'h00); b.push_back(8'h09);
        b.push_back(udl[15:8]); b.push_back(udl[7:0]); b.push_back(8'h00); b.push_back(8'h00);
        b.push_back(8'hA5); b.push_back(8'hA5); b.push_back(8'h5A); b.push_back(8'h5A);
        for (int i = 0; i < 4; i++) b.push_back(global_counter[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) b.push_back(m_seq[31-8*i -: 8]);
        b.push_back(8'h00); b.push_back(8'h00);
        while (b.size() < L - 4) b.push_back(8'hE5);
        crc = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            crc = crc ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
        end
        crc = ~crc;
        b.push_back(crc[7:0]); b.push_back(crc[15:8]); b.push_back(crc[23:16]); b.push_back(crc[31:24]);
        foreach (b[i]) exp_q.push_back(b[i]);
        exp_len_q.push_back(L);
        m_seq = m_seq + 32'd1;
        m_idx = (m_idx + 1) % 4;
    endtask

    // ---------------- monitor ----------------
    logic [7:0] rx[$], last_frame[$], mon_ef[$];
    bit         mon_in = 0, mon_first = 1, allow_abort = 0;
    int         mon_frames = 0, idle_cnt = 0, exp_gap = 1, mon_L, mon_nmis;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            mon_in = 0;
            rx.delete();
        end else if (xgmii_txc == 8'h01) begin
            check("pre_word", xgmii_txd, PRE_W);
            if (!mon_first) check("ifg_words", 64'(idle_cnt), 64'(exp_gap));
            mon_first = 0;
            mon_in = 1;
            rx.delete();
        end else if (mon_in && xgmii_txc == 8'h00) begin
            for (int k = 0; k < 8; k++) rx.push_back(xgmii_txd[8*k +: 8]);
        end else if (mon_in && xgmii_txc == 8'hFF && xgmii_txd[7:0] == 8'hFD) begin
            check("term_word", xgmii_txd, TERM_W);
            mon_in = 0;
            idle_cnt = 0;
            mon_frames++;
            if (exp_len_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_frame: got %0d bytes, expected no frame", rx.size());
            end else begin
                mon_L = exp_len_q.pop_front();
                mon_ef.delete();
                for (int i = 0; i < mon_L; i++) mon_ef.push_back(exp_q.pop_front());
                check("frame_len", 64'(rx.size()), 64'(mon_L));
                mon_nmis = 0;
                for (int i = 0; i < mon_L; i++)
                    if (i >= rx.size() || rx[i] !== mon_ef[i]) mon_nmis++;
                check("frame_bytes_mismatched", 64'(mon_nmis), 64'd0);
                if (rx.size() == mon_L)
                    check("fcs", {rx[mon_L-1], rx[mon_L-2], rx[mon_L-3], rx[mon_L-4]},
                          {mon_ef[mon_L-1], mon_ef[mon_L-2], mon_ef[mon_L-3], mon_ef[mon_L-4]});
            end
            last_frame = rx;
        end else if (mon_in) begin
            if (!allow_abort) begin
                n_checks++; n_fail++;
                $display("FAIL frame_truncated: got ctl %0h after %0d bytes, expected data or terminate",
                         xgmii_txc, rx.size());
            end
            mon_in = 0;
        end else if (xgmii_txc == 8'hFF) begin
            idle_cnt++;
        end else begin
            n_checks++; n_fail++;
            $display("FAIL stray_ctl: got txc %0h outside a frame, expected FF", xgmii_txc);
        end
    end

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [15:0] flen;
        logic [31:0] ifg;
        logic [31:0] burst;
        int          exp_L;
        int          exp_gap;
        logic [15:0] exp_iplen;
        logic [15:0] exp_udplen;
    } vec_t;

    vec_t tbl[6];

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 4000) begin tick(); n++; end
        check({nm, "_done_set"}, done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        tbl[0] = '{16'd64,   32'd1, 32'd3, 64,   1, 16'd46,   16'd26};
        tbl[1] = '{16'd1000, 32'd2, 32'd1, 1000, 2, 16'd982,  16'd962};
        tbl[2] = '{16'd20,   32'd0, 32'd2, 64,   1, 16'd46,   16'd26};
        tbl[3] = '{16'd9000, 32'd3, 32'd2, 1512, 3, 16'd1494, 16'd1474};
        tbl[4] = '{16'd1003, 32'd1, 32'd1, 1000, 1, 16'd982,  16'd962};
        tbl[5] = '{16'd64,   32'd1, 32'd6, 64,   1, 16'd46,   16'd26};

        #2 sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_txd", xgmii_txd, IDLE_W);
        check("rst_txc", xgmii_txc, 8'hFF);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_frames_sent", frames_sent, 32'd0);
        check("rst_tx_pps", tx_pps, 32'd0);
        tick();
        sys_rst_n = 1'b1;
        repeat (2) tick();

        // enable -> PRE on the wire two clocks later
        frame_len = 16'd64; ifg = 32'd1; burst_count = 32'd1; exp_gap = 1; mon_first = 1;
        push_frame(64);
        enable = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        check("lat_cycle1_txc", xgmii_txc, 8'hFF);
        @(posedge sys_clk); @(negedge sys_clk);
        check("lat_cycle2_txd", xgmii_txd, PRE_W);
        #1;
        wait_done("lat");
        enable = 1'b0;
        repeat (2) tick();

        foreach (tbl[v]) begin
            frame_len = tbl[v].flen; ifg = tbl[v].ifg; burst_count = tbl[v].burst;
            exp_gap = tbl[v].exp_gap; mon_first = 1;
            for (int f = 0; f < int'(tbl[v].burst); f++) push_frame(tbl[v].exp_L);
            enable = 1'b1;
            wait_done($sformatf("vec%0d", v));
            repeat (3) tick();
            check($sformatf("vec%0d_done_held", v), done, 1'b1);
            check($sformatf("vec%0d_frames_sent", v), frames_sent, tbl[v].burst);
            check($sformatf("vec%0d_busy_idle", v), busy, 1'b0);
            check($sformatf("vec%0d_ip_len", v), {last_frame[16], last_frame[17]}, tbl[v].exp_iplen);
            check($sformatf("vec%0d_udp_len", v), {last_frame[38], last_frame[39]}, tbl[v].exp_udplen);
            enable = 1'b0;
            repeat (2) tick();
            check($sformatf("vec%0d_done_clr", v), done, 1'b0);
            check($sformatf("vec%0d_frames_clr", v), frames_sent, 32'd0);
        end

`ifdef PKTGEN_STATS_EN
        sec_oneshot = 1'b1; tick(); sec_oneshot = 1'b0;
        frame_len = 16'd64; ifg = 32'd1; burst_count = 32'd3; exp_gap = 1; mon_first = 1;
        for (int f = 0; f < 3; f++) push_frame(64);
        enable = 1'b1;
        wait_done("stats");
        sec_oneshot = 1'b1; tick(); sec_oneshot = 1'b0;
        check("stats_pps", tx_pps, 32'd3);
        check("stats_thr", tx_throughput, 32'd1536);
        enable = 1'b0;
        repeat (2) tick();
`else
        check("stats_pps_zero", tx_pps, 32'd0);
        check("stats_thr_zero", tx_throughput, 32'd0);
`endif

        // enable dropped inside frame 2: frames 1 and 2 complete, nothing after
        frame_len = 16'd64; ifg = 32'd1; burst_count = 32'd0; exp_gap = 1; mon_first = 1;
        push_frame(64); push_frame(64);
        base = mon_frames;
        enable = 1'b1;
        n = 0;
        while (!(mon_frames == base + 1 && mon_in && rx.size() >= 40) && n < 200) begin tick(); n++; end
        check("drop_reached_frame2", 64'(n < 200), 64'd1);
        enable = 1'b0;
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        repeat (2) tick();
        check("drop_busy", busy, 1'b0);
        check("drop_done", done, 1'b0);
        check("drop_frames_clr", frames_sent, 32'd0);
        repeat (30) tick();
        check("drop_frame_count", 64'(mon_frames - base), 64'd2);

        // reset asserted mid-frame forces idle immediately
        mon_first = 1;
        enable = 1'b1;
        n = 0;
        while (!(mon_in && rx.size() >= 24) && n < 200) begin tick(); n++; end
        allow_abort = 1;
        @(negedge sys_clk);
        #1 sys_rst_n = 1'b0;
        #1;
        check("midrst_txd", xgmii_txd, IDLE_W);
        check("midrst_txc", xgmii_txc, 8'hFF);
        check("midrst_busy", busy, 1'b0);
        enable = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        m_seq = 32'd0; m_idx = 0;
        repeat (2) tick();
        allow_abort = 0;

        // timestamp placement, seq restarts at 0 after reset
        global_counter = 32'h1234_5678;
        burst_count = 32'd1; mon_first = 1;
        push_frame(64);
        enable = 1'b1;
        wait_done("ts");
        check("ts_bytes", {last_frame[46], last_frame[47], last_frame[48], last_frame[49]}, 32'h1234_5678);
        check("seq_after_reset", {last_frame[50], last_frame[51], last_frame[52], last_frame[53]}, 32'd0);
        enable = 1'b0;
        repeat (4) tick();

        check("scoreboard_empty", 64'(exp_len_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
